// File: rtl/window_cache_filler.sv
// Packs a raster pixel stream into WORDS-pixel cache words and writes them into a
// circular set of ROWS cache rows, stalling the stream while every row is unconsumed.
module window_cache_filler #(
    parameter int PIX_WIDTH = 8,
    parameter int WORDS     = 4,
    parameter int BLOCKS    = 4,
    parameter int ROWS      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [PIX_WIDTH-1:0]          pix_data,
    input  logic                          pix_sof,
    input  logic                          row_release,
    output logic [$clog2(ROWS)-1:0]       waddrY,
    output logic [$clog2(BLOCKS)-1:0]     waddrBlock,
    output logic [WORDS*PIX_WIDTH-1:0]    wdata,
    output logic                          we,
    output logic                          row_done,
    output logic [$clog2(ROWS)-1:0]       row_done_idx,
    output logic [$clog2(ROWS+1)-1:0]     rows_full
);
    localparam int EW = $clog2(WORDS);
    localparam int BW = $clog2(BLOCKS);
    localparam int YW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS+1);

    logic [EW-1:0] elm;
    logic [BW-1:0] blk;
    logic [YW-1:0] row;
    // The last lane never needs storage: it goes straight from pix_data into wdata.
    logic [WORDS-2:0][PIX_WIDTH-1:0] pack;

    logic accept, word_end, row_end, release_ok;

    assign pix_ready  = !rst && (rows_full != FW'(ROWS));
    assign accept     = pix_valid && pix_ready;
    assign word_end   = accept && !pix_sof && (elm == EW'(WORDS-1));
    assign row_end    = word_end && (blk == BW'(BLOCKS-1));
    assign release_ok = row_release && (rows_full != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            elm          <= '0;
            blk          <= '0;
            row          <= '0;
            pack         <= '0;
            we           <= 1'b0;
            row_done     <= 1'b0;
            waddrY       <= '0;
            waddrBlock   <= '0;
            wdata        <= '0;
            row_done_idx <= '0;
            rows_full    <= '0;
        end else begin
            we       <= word_end;
            row_done <= row_end;
            if (accept) begin
                if (pix_sof) begin
                    pack[0] <= pix_data;
                    elm     <= EW'(1);
                    blk     <= '0;
                    row     <= '0;
                end else if (word_end) begin
                    elm        <= '0;
                    wdata      <= {pix_data, pack};
                    waddrBlock <= blk;
                    waddrY     <= row;
                    if (row_end) begin
                        blk          <= '0;
                        row          <= (row == YW'(ROWS-1)) ? '0 : row + YW'(1);
                        row_done_idx <= row;
                    end else begin
                        blk <= blk + BW'(1);
                    end
                end else begin
                    pack[elm] <= pix_data;
                    elm       <= elm + EW'(1);
                end
            end
            // A frame start wipes occupancy; completion and release in one cycle cancel.
            if (accept && pix_sof)
                rows_full <= '0;
            else if (row_end && !release_ok)
                rows_full <= rows_full + FW'(1);
            else if (!row_end && release_ok)
                rows_full <= rows_full - FW'(1);
        end
    end
endmodule

// File: tb/tb_window_cache_filler.sv
// Bench for window_cache_filler: a frame-level reference packer checked every cycle,
// plus directed literal checks that pin the reference itself.
module tb_window_cache_filler;
    localparam int PIX_WIDTH = 8;
    localparam int WORDS     = 4;
    localparam int BLOCKS    = 4;
    localparam int ROWS      = 3;
    localparam int WW        = WORDS*PIX_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      pix_valid = 1'b0;
    logic                      pix_ready;
    logic [PIX_WIDTH-1:0]      pix_data = '0;
    logic                      pix_sof = 1'b0;
    logic                      row_release = 1'b0;
    logic [$clog2(ROWS)-1:0]   waddrY;
    logic [$clog2(BLOCKS)-1:0] waddrBlock;
    logic [WW-1:0]             wdata;
    logic                      we;
    logic                      row_done;
    logic [$clog2(ROWS)-1:0]   row_done_idx;
    logic [$clog2(ROWS+1)-1:0] rows_full;

    window_cache_filler #(.PIX_WIDTH(PIX_WIDTH), .WORDS(WORDS), .BLOCKS(BLOCKS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .row_release(row_release),
        .waddrY(waddrY), .waddrBlock(waddrBlock), .wdata(wdata), .we(we),
        .row_done(row_done), .row_done_idx(row_done_idx), .rows_full(rows_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pixels of the current word in a queue, words counted from frame start.
    logic [PIX_WIDTH-1:0] m_word[$];
    int                   m_widx = 0;
    int                   m_full = 0;
    logic                 m_we = 0, m_rd = 0;
    logic [WW-1:0]        m_wdata = '0;
    int                   m_y = 0, m_blk = 0, m_rdi = 0;
    bit                   started = 0;

    always @(posedge clk) begin
        bit acc, rel;
        int inc;
        started = 1;
        m_we = 0;
        m_rd = 0;
        if (rst) begin
            m_word.delete();
            m_widx = 0; m_full = 0; m_wdata = '0; m_y = 0; m_blk = 0; m_rdi = 0;
        end else begin
            acc = pix_valid && (m_full != ROWS);
            rel = row_release && (m_full != 0);
            inc = 0;
            if (acc && pix_sof) begin
                m_word.delete();
                m_word.push_back(pix_data);
                m_widx = 0;
                m_full = 0;
            end else begin
                if (acc) begin
                    m_word.push_back(pix_data);
                    if (m_word.size() == WORDS) begin
                        m_we = 1;
                        for (int i = 0; i < WORDS; i++) m_wdata[i*PIX_WIDTH +: PIX_WIDTH] = m_word[i];
                        m_blk = m_widx % BLOCKS;
                        m_y   = (m_widx / BLOCKS) % ROWS;
                        m_widx++;
                        m_word.delete();
                        if (m_blk == BLOCKS-1) begin
                            m_rd = 1; m_rdi = m_y; inc = 1;
                        end
                    end
                end
                m_full = m_full + inc - (rel ? 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pix_ready", pix_ready, (!rst && m_full != ROWS));
            chk("we", we, m_we);
            chk("row_done", row_done, m_rd);
            chk("wdata", wdata, m_wdata);
            chk("waddrY", waddrY, m_y);
            chk("waddrBlock", waddrBlock, m_blk);
            chk("row_done_idx", row_done_idx, m_rdi);
            chk("rows_full", rows_full, m_full);
            chk("rows_full_bound", rows_full <= ROWS, 1);
        end
    end

    // Present one pixel and hold it until accepted (bounded wait).
    task automatic push(input logic [PIX_WIDTH-1:0] d, input logic sof);
        int n;
        pix_valid = 1'b1; pix_data = d; pix_sof = sof;
        n = 0;
        forever begin
            @(negedge clk);
            if (pix_ready) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic release_pulse();
        row_release = 1'b1;
        @(posedge clk); #1;
        row_release = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", pix_ready, 0);
        chk("rst_we", we, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", pix_ready, 1);
        chk("post_rst_full", rows_full, 0);

        // First row: 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b0);
            if (i == 3) chk("t1_w0", wdata, 32'h03020100);
            if (i == 7) chk("t1_w1", wdata, 32'h07060504);
        end
        chk("t1_w3", wdata, 32'h0F0E0D0C);
        chk("t1_blk", waddrBlock, 3);
        chk("t1_done", row_done, 1);
        chk("t1_idx", row_done_idx, 0);
        chk("t1_full", rows_full, 1);

        // Fill all rows, then stall
        for (int i = 16; i < 48; i++) push(8'(i), 1'b0);
        chk("t2_full", rows_full, 3);
        chk("t2_ready", pix_ready, 0);
        chk("t2_y", waddrY, 2);
        pix_valid = 1'b1; pix_data = 8'h30;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_held_full", rows_full, 3);
        release_pulse();
        chk("t2_rel_full", rows_full, 2);
        chk("t2_rel_ready", pix_ready, 1);
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h30 + i), 1'b0);
            if (i == 3) begin
                chk("t2_wrap_y", waddrY, 0);
                chk("t2_wrap_w", wdata, 32'h33323130);
            end
        end
        chk("t2_idx", row_done_idx, 0);
        chk("t2_full3", rows_full, 3);
        repeat (3) release_pulse();
        chk("t2_empty", rows_full, 0);

        // Release coincident with row 1 completion
        for (int i = 0; i < 16; i++) push(8'(i), i == 0);
        chk("t3_full1", rows_full, 1);
        for (int i = 0; i < 15; i++) push(8'(8'h40 + i), 1'b0);
        row_release = 1'b1;
        push(8'h4F, 1'b0);
        row_release = 1'b0;
        chk("t3_done", row_done, 1);
        chk("t3_idx", row_done_idx, 1);
        chk("t3_full_same", rows_full, 1);

        // Frame start discards the partial word
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i), 1'b0);
        push(8'hAA, 1'b1);
        chk("t4_sof_full", rows_full, 0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b0);
        push(8'hDD, 1'b0);
        chk("t4_we", we, 1);
        chk("t4_w", wdata, 32'hDDCCBBAA);
        chk("t4_y", waddrY, 0);
        chk("t4_blk", waddrBlock, 0);

        // Release on empty, then reset mid-word
        release_pulse();
        chk("t5_no_underflow", rows_full, 0);
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_we", we, 0);
        chk("t5_rst_wdata", wdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_post_we", we, 0);
        chk("t5_post_ready", pix_ready, 1);

        // Random gaps and releases over 10 frames
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < WORDS*BLOCKS*ROWS*2; i++) begin
                row_release = ($urandom_range(0, 3) == 0) || (m_full == ROWS);
                push(8'($urandom), i == 0);
                row_release = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
